dcd_fuse_loader: RTL and testbench
==================================

# dcd_fuse_loader

Fuse-side controller for the D-cache data array redundancy registers. On a start pulse it snapshots an 8-entry repair table, writes every redundancy register (rid 0..7) through the array's fuse write port, and reads each one back. A read-back mismatch is flagged as an error with the first failing rid. It sits between the fuse/efuse logic and the `bw_r_dcd` fuse pins, and drives the `fuse_dcd_*` inputs that the array receives.

## Interface
- Clocking: one clock; reset is synchronous and active-low.
- Array fuse registers are clocked by the same clock as this block (`efc_spc_fuse_clk1` tied to `rclk` at the top level).
- Parameters:
  - `READ_LAT`, default 1: cycles from `fuse_dcd_rid` presented (wren low) to valid `dcd_fuse_repair_*` (1..3).
  - `VERIFY`, default 1: 1 = run read-back phase; 0 = skip to DONE after writes.
- Ports:
  - `rclk` in 1: clock.
  - `rst_l` in 1: synchronous active-low reset.
  - `start` in 1: single-cycle start request; honoured only in IDLE or DONE.
  - `fuse_table` in 80: entry k = bits [10k+9:10k]; [9:8] = repair_en, [7:0] = repair_value.
  - `fuse_dcd_wren` out 1: redundancy register write enable.
  - `fuse_dcd_rid` out 3: redundancy register id.
  - `fuse_dcd_repair_value` out 8: write data.
  - `fuse_dcd_repair_en` out 2: write enable bits.
  - `dcd_fuse_repair_value` in 8: read-back data from array.
  - `dcd_fuse_repair_en` in 2: read-back enable bits from array.
  - `busy` out 1: sequence in progress.
  - `done` out 1: sequence complete; sticky until next accepted start or reset.
  - `err` out 1: at least one mismatch in last sequence; sticky like `done`.
  - `err_rid` out 3: rid of first mismatch (0 if none).
  - `err_cnt` out 4: number of mismatching rids (0..8).

## Operation
- States: IDLE, WRITE, RD_ADDR, RD_WAIT, CHECK, DONE.
- IDLE/DONE + `start`: snapshot `fuse_table` into internal 8×10 regs; clear `done`, `err`, `err_rid`, `err_cnt`; set rid counter to 0; go to WRITE. Table changes after the snapshot have no effect.
- WRITE: drive `fuse_dcd_wren`=1, rid=counter, value/en from the snapshot entry.
  - Counter increments each cycle.
  - After rid 7: go to RD_ADDR with counter=0 (VERIFY=1), or to DONE (VERIFY=0).
  - Entries with en=2'b00 are still written.
- RD_ADDR: wren=0, rid=counter. Go to RD_WAIT, which holds the rid for READ_LAT-1 further cycles (zero cycles when READ_LAT=1), then go to CHECK.
- CHECK: rid held. Compare {`dcd_fuse_repair_en`,`dcd_fuse_repair_value`} with the snapshot entry.
  - On mismatch: `err_cnt`+1 and `err`=1. If this is the first mismatch, `err_rid`=counter.
  - If counter==7, go to DONE; otherwise counter+1 and go to RD_ADDR.
- DONE: `done`=1, `busy`=0; wait for `start`.
- Output defaults outside WRITE: `fuse_dcd_wren`=0, `fuse_dcd_repair_value`=0, `fuse_dcd_repair_en`=0.
- `fuse_dcd_rid`:
  - holds the counter in WRITE, RD_ADDR, RD_WAIT and CHECK;
  - is 0 in IDLE and DONE.
- `start` while busy is ignored: no restart, no side effects.
- `err_cnt` is 4 bits, so 8 mismatches fits without saturation.

## Timing
- All outputs are registered. Reset value of every output is 0; the snapshot table also resets to 0.
- `rst_l` low mid-sequence: on that edge `fuse_dcd_wren` drops to 0, state goes to IDLE, and no partial write repeats. The array keeps whatever was already written.
- `start` sampled at edge t: `busy`=1 and first write (rid 0) visible from t+1. Writes occupy t+1..t+8.
- VERIFY=1: each rid takes READ_LAT+1 cycles. `done` rises at t+9+8·(READ_LAT+1), i.e. t+25 for READ_LAT=1.
- VERIFY=0: `done` rises at t+9.
- `busy` and `done` are never both 1.
- `start` in the same cycle as DONE entry is ignored; `start` on a later DONE cycle restarts the sequence.

## Structure
- Shared package `dcd_fuse_pkg`:
  - state enum;
  - `DCD_FUSE_NRID`=8 and `DCD_FUSE_ENTRY_W`=10;
  - field offsets for en/value within an entry.
- Behavioural model sub-module `dcd_fuse_regs_model`, used only by the bench: 8×10 register file with the array's fuse port and READ_LAT read delay, plus a fault-inject hook for a stuck bit per rid.

## Test plan
- Reset, then `start` with entry k = {2'b01, 8'h10+k}, READ_LAT=1:
  - wren high for exactly 8 cycles with rid 0..7;
  - `done` at start+25;
  - `err`=0, `err_cnt`=0.
- Model forces rid 5 value bit 0 stuck-at-1, table entry 5 = 8'hA4 → `err`=1, `err_rid`=5, `err_cnt`=1.
- Stuck faults on rids 2, 3 and 7 → `err_rid`=2, `err_cnt`=3.
- `rst_l` low on the 4th WRITE cycle → next cycle wren=0, all outputs 0. A fresh `start` completes cleanly in 25 cycles.
- `start` pulsed while busy, and `fuse_table` changed mid-run → no restart; read-back compares against the snapshot values.
- VERIFY=0 → `done` at start+9, no read cycles. READ_LAT=3 → `done` at start+41.

Source files
------------

// File: rtl/dcd_fuse_pkg.sv
// Shared definitions for the D-cache redundancy fuse loader and its array model.
package dcd_fuse_pkg;

  localparam int DCD_FUSE_NRID     = 8;
  localparam int DCD_FUSE_ENTRY_W  = 10;
  localparam int DCD_FUSE_VAL_LSB  = 0;
  localparam int DCD_FUSE_VAL_W    = 8;
  localparam int DCD_FUSE_EN_LSB   = 8;
  localparam int DCD_FUSE_EN_W     = 2;
  localparam int DCD_FUSE_TABLE_W  = DCD_FUSE_NRID * DCD_FUSE_ENTRY_W;

  typedef enum logic [2:0] {
    DCD_ST_IDLE    = 3'd0,
    DCD_ST_WRITE   = 3'd1,
    DCD_ST_RD_ADDR = 3'd2,
    DCD_ST_RD_WAIT = 3'd3,
    DCD_ST_CHECK   = 3'd4,
    DCD_ST_DONE    = 3'd5
  } dcd_fuse_state_e;

  function automatic logic [DCD_FUSE_ENTRY_W-1:0] dcd_fuse_entry(
    input logic [DCD_FUSE_TABLE_W-1:0] tbl,
    input logic [2:0]                  rid
  );
    return tbl[int'(rid)*DCD_FUSE_ENTRY_W +: DCD_FUSE_ENTRY_W];
  endfunction

endpackage

// File: rtl/dcd_fuse_regs_model.sv
// Behavioural redundancy register file with the array fuse port, a READ_LAT
// deep read pipeline and a per-bit stuck-at-1 fault hook on the read path.
module dcd_fuse_regs_model
  import dcd_fuse_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic                        rclk,
  input  logic                        rst_l,
  input  logic                        fuse_dcd_wren,
  input  logic [2:0]                  fuse_dcd_rid,
  input  logic [7:0]                  fuse_dcd_repair_value,
  input  logic [1:0]                  fuse_dcd_repair_en,
  input  logic [DCD_FUSE_TABLE_W-1:0] stuck1_mask,
  output logic [7:0]                  dcd_fuse_repair_value,
  output logic [1:0]                  dcd_fuse_repair_en
);

  logic [DCD_FUSE_ENTRY_W-1:0] mem_r  [DCD_FUSE_NRID];
  logic [DCD_FUSE_ENTRY_W-1:0] pipe_r [READ_LAT];

  // Register file write port and read-data pipeline.
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      for (int k = 0; k < DCD_FUSE_NRID; k++) mem_r[k] <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_r[i] <= '0;
    end else begin
      if (fuse_dcd_wren) begin
        mem_r[fuse_dcd_rid] <= {fuse_dcd_repair_en, fuse_dcd_repair_value};
      end
      pipe_r[0] <= mem_r[fuse_dcd_rid] | dcd_fuse_entry(stuck1_mask, fuse_dcd_rid);
      for (int i = 1; i < READ_LAT; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign dcd_fuse_repair_en    = pipe_r[READ_LAT-1][DCD_FUSE_EN_LSB +: DCD_FUSE_EN_W];
  assign dcd_fuse_repair_value = pipe_r[READ_LAT-1][DCD_FUSE_VAL_LSB +: DCD_FUSE_VAL_W];

endmodule

// File: rtl/dcd_fuse_loader.sv
// Loads the D-cache data array redundancy registers from a snapshot of the
// fuse repair table, then optionally reads each one back and logs mismatches.
module dcd_fuse_loader
  import dcd_fuse_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int VERIFY   = 1
) (
  input  logic                        rclk,
  input  logic                        rst_l,
  input  logic                        start,
  input  logic [DCD_FUSE_TABLE_W-1:0] fuse_table,
  output logic                        fuse_dcd_wren,
  output logic [2:0]                  fuse_dcd_rid,
  output logic [7:0]                  fuse_dcd_repair_value,
  output logic [1:0]                  fuse_dcd_repair_en,
  input  logic [7:0]                  dcd_fuse_repair_value,
  input  logic [1:0]                  dcd_fuse_repair_en,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [2:0]                  err_rid,
  output logic [3:0]                  err_cnt
);

  localparam logic [2:0] S_IDLE    = DCD_ST_IDLE;
  localparam logic [2:0] S_WRITE   = DCD_ST_WRITE;
  localparam logic [2:0] S_RD_ADDR = DCD_ST_RD_ADDR;
  localparam logic [2:0] S_RD_WAIT = DCD_ST_RD_WAIT;
  localparam logic [2:0] S_CHECK   = DCD_ST_CHECK;
  localparam logic [2:0] S_DONE    = DCD_ST_DONE;
  localparam logic [2:0] LAST_RID  = 3'(DCD_FUSE_NRID - 1);
  localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

  logic [2:0]                  state_r, state_s;
  logic [2:0]                  cnt_r, cnt_s;
  logic [1:0]                  wait_r, wait_s;
  logic [DCD_FUSE_ENTRY_W-1:0] tbl_r [DCD_FUSE_NRID];
  logic                        err_r, err_s;
  logic [2:0]                  err_rid_r, err_rid_s;
  logic [3:0]                  err_cnt_r, err_cnt_s;
  logic                        accept_s, mismatch_s, in_seq_s;
  logic [DCD_FUSE_ENTRY_W-1:0] wr_entry_s;

  // Sequencer next-state, error bookkeeping and next write entry.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    wait_s     = wait_r;
    err_s      = err_r;
    err_rid_s  = err_rid_r;
    err_cnt_s  = err_cnt_r;
    accept_s   = start && ((state_r == S_IDLE) || (state_r == S_DONE));
    mismatch_s = ({dcd_fuse_repair_en, dcd_fuse_repair_value} != tbl_r[cnt_r]);
    case (state_r)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          state_s   = S_WRITE;
          cnt_s     = 3'd0;
          err_s     = 1'b0;
          err_rid_s = 3'd0;
          err_cnt_s = 4'd0;
        end else begin
          state_s = state_r;
        end
      end
      S_WRITE: begin
        if (cnt_r == LAST_RID) begin
          cnt_s   = 3'd0;
          state_s = (VERIFY != 0) ? S_RD_ADDR : S_DONE;
        end else begin
          cnt_s = cnt_r + 3'd1;
        end
      end
      S_RD_ADDR: begin
        wait_s  = 2'd1;
        state_s = (READ_LAT > 1) ? S_RD_WAIT : S_CHECK;
      end
      S_RD_WAIT: begin
        if (wait_r == WAIT_LAST) begin
          state_s = S_CHECK;
        end else begin
          wait_s = wait_r + 2'd1;
        end
      end
      S_CHECK: begin
        if (mismatch_s) begin
          err_s     = 1'b1;
          err_cnt_s = err_cnt_r + 4'd1;
          err_rid_s = err_r ? err_rid_r : cnt_r;
        end else begin
          err_s = err_r;
        end
        if (cnt_r == LAST_RID) begin
          state_s = S_DONE;
        end else begin
          cnt_s   = cnt_r + 3'd1;
          state_s = S_RD_ADDR;
        end
      end
      default: state_s = S_IDLE;
    endcase
    // The first write must come straight from the table being snapshotted.
    wr_entry_s = accept_s ? dcd_fuse_entry(fuse_table, 3'd0) : tbl_r[cnt_s];
    in_seq_s   = (state_s == S_WRITE) || (state_s == S_RD_ADDR) ||
                 (state_s == S_RD_WAIT) || (state_s == S_CHECK);
  end

  // Sequencer state, snapshot table and sticky error state.
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      state_r   <= S_IDLE;
      cnt_r     <= 3'd0;
      wait_r    <= 2'd0;
      err_r     <= 1'b0;
      err_rid_r <= 3'd0;
      err_cnt_r <= 4'd0;
      for (int k = 0; k < DCD_FUSE_NRID; k++) tbl_r[k] <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      wait_r    <= wait_s;
      err_r     <= err_s;
      err_rid_r <= err_rid_s;
      err_cnt_r <= err_cnt_s;
      if (accept_s) begin
        for (int k = 0; k < DCD_FUSE_NRID; k++) tbl_r[k] <= dcd_fuse_entry(fuse_table, 3'(k));
      end
    end
  end

  // Registered fuse port and status outputs, derived from the next state.
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      fuse_dcd_wren         <= 1'b0;
      fuse_dcd_rid          <= 3'd0;
      fuse_dcd_repair_value <= 8'd0;
      fuse_dcd_repair_en    <= 2'd0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
    end else begin
      fuse_dcd_wren         <= (state_s == S_WRITE);
      fuse_dcd_rid          <= in_seq_s ? cnt_s : 3'd0;
      fuse_dcd_repair_value <= (state_s == S_WRITE) ? wr_entry_s[DCD_FUSE_VAL_LSB +: DCD_FUSE_VAL_W] : 8'd0;
      fuse_dcd_repair_en    <= (state_s == S_WRITE) ? wr_entry_s[DCD_FUSE_EN_LSB +: DCD_FUSE_EN_W] : 2'd0;
      busy                  <= in_seq_s;
      done                  <= (state_s == S_DONE);
    end
  end

  assign err     = err_r;
  assign err_rid = err_rid_r;
  assign err_cnt = err_cnt_r;

endmodule

// File: tb/tb_dcd_fuse_loader.sv
// Directed bench: three loader configurations each paired with an array model;
// a scoreboard queue holds the expected write stream of the main instance.
module tb_dcd_fuse_loader;
  import dcd_fuse_pkg::*;

  logic        rclk = 1'b0;
  logic        rst_l, mrst_l, start;
  logic [79:0] fuse_table, stuck1_mask;

  logic       wren_a, wren_b, wren_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic       err_a, err_b, err_c;
  logic [2:0] rid_a, rid_b, rid_c, erid_a, erid_b, erid_c;
  logic [7:0] val_a, val_b, val_c, rbv_a, rbv_b, rbv_c;
  logic [1:0] en_a, en_b, en_c, rbe_a, rbe_b, rbe_c;
  logic [3:0] ecnt_a, ecnt_b, ecnt_c;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [9:0] exp_q [$];

  always #5 rclk = ~rclk;

  dcd_fuse_loader #(.READ_LAT(1), .VERIFY(1)) dut_a (
    .rclk(rclk), .rst_l(rst_l), .start(start), .fuse_table(fuse_table),
    .fuse_dcd_wren(wren_a), .fuse_dcd_rid(rid_a), .fuse_dcd_repair_value(val_a),
    .fuse_dcd_repair_en(en_a), .dcd_fuse_repair_value(rbv_a), .dcd_fuse_repair_en(rbe_a),
    .busy(busy_a), .done(done_a), .err(err_a), .err_rid(erid_a), .err_cnt(ecnt_a));
  dcd_fuse_regs_model #(.READ_LAT(1)) mdl_a (
    .rclk(rclk), .rst_l(mrst_l), .fuse_dcd_wren(wren_a), .fuse_dcd_rid(rid_a),
    .fuse_dcd_repair_value(val_a), .fuse_dcd_repair_en(en_a), .stuck1_mask(stuck1_mask),
    .dcd_fuse_repair_value(rbv_a), .dcd_fuse_repair_en(rbe_a));

  dcd_fuse_loader #(.READ_LAT(1), .VERIFY(0)) dut_b (
    .rclk(rclk), .rst_l(rst_l), .start(start), .fuse_table(fuse_table),
    .fuse_dcd_wren(wren_b), .fuse_dcd_rid(rid_b), .fuse_dcd_repair_value(val_b),
    .fuse_dcd_repair_en(en_b), .dcd_fuse_repair_value(rbv_b), .dcd_fuse_repair_en(rbe_b),
    .busy(busy_b), .done(done_b), .err(err_b), .err_rid(erid_b), .err_cnt(ecnt_b));
  dcd_fuse_regs_model #(.READ_LAT(1)) mdl_b (
    .rclk(rclk), .rst_l(mrst_l), .fuse_dcd_wren(wren_b), .fuse_dcd_rid(rid_b),
    .fuse_dcd_repair_value(val_b), .fuse_dcd_repair_en(en_b), .stuck1_mask(stuck1_mask),
    .dcd_fuse_repair_value(rbv_b), .dcd_fuse_repair_en(rbe_b));

  dcd_fuse_loader #(.READ_LAT(3), .VERIFY(1)) dut_c (
    .rclk(rclk), .rst_l(rst_l), .start(start), .fuse_table(fuse_table),
    .fuse_dcd_wren(wren_c), .fuse_dcd_rid(rid_c), .fuse_dcd_repair_value(val_c),
    .fuse_dcd_repair_en(en_c), .dcd_fuse_repair_value(rbv_c), .dcd_fuse_repair_en(rbe_c),
    .busy(busy_c), .done(done_c), .err(err_c), .err_rid(erid_c), .err_cnt(ecnt_c));
  dcd_fuse_regs_model #(.READ_LAT(3)) mdl_c (
    .rclk(rclk), .rst_l(mrst_l), .fuse_dcd_wren(wren_c), .fuse_dcd_rid(rid_c),
    .fuse_dcd_repair_value(val_c), .fuse_dcd_repair_en(en_c), .stuck1_mask(stuck1_mask),
    .dcd_fuse_repair_value(rbv_c), .dcd_fuse_repair_en(rbe_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One full sequence from a start pulse; disturb pulses start while busy,
  // corrupts the live table mid-run and pulses start on the DONE-entry edge.
  task automatic run_seq(input logic [79:0] tbl, input logic [2:0] e_rid,
                         input logic [3:0] e_cnt, input bit disturb);
    int wr_n = 0;
    int da = 0, db = 0, dc = 0;
    logic [9:0] e;
    fuse_table = tbl;
    for (int k = 0; k < 8; k++) exp_q.push_back(tbl[k*10 +: 10]);
    start = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge rclk);
      start = 1'b0;
      if (i == 1) chk("busy_rise", {31'd0, busy_a}, 32'd1);
      if (wren_a) begin
        chk("wr_rid", {29'd0, rid_a}, wr_n);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_data", {22'd0, en_a, val_a}, {22'd0, e});
        end
        wr_n++;
      end
      if (done_a && da == 0) da = i;
      if (done_b && db == 0) db = i;
      if (done_c && dc == 0) dc = i;
      chk("busy_and_done", {31'd0, busy_a & done_a}, 32'd0);
      if (disturb && (i == 4 || i == 24)) start = 1'b1;
      if (disturb && i == 4) fuse_table = ~tbl;
    end
    chk("wr_count", wr_n, 32'd8);
    chk("done_at_25", da, 32'd25);
    chk("v0_done_at_9", db, 32'd9);
    chk("lat3_done_at_41", dc, 32'd41);
    chk("v0_err", {31'd0, err_b}, 32'd0);
    chk("done_hold", {30'd0, busy_a, done_a}, 32'd1);
    chk("err", {31'd0, err_a}, {31'd0, (e_cnt != 4'd0)});
    chk("err_rid", {29'd0, erid_a}, {29'd0, e_rid});
    chk("err_cnt", {28'd0, ecnt_a}, {28'd0, e_cnt});
    exp_q.delete();
  endtask

  initial begin
    logic [79:0] tbl1, tbl2, tbl6;
    for (int k = 0; k < 8; k++) tbl1[k*10 +: 10] = {2'b01, 8'(8'h10 + k)};
    rst_l = 1'b0; mrst_l = 1'b0; start = 1'b0;
    fuse_table = 80'd0; stuck1_mask = 80'd0;
    repeat (3) @(negedge rclk);
    chk("reset_outs", {8'd0, wren_a, rid_a, val_a, en_a, busy_a, done_a, err_a, erid_a, ecnt_a}, 32'd0);
    rst_l = 1'b1; mrst_l = 1'b1;
    @(negedge rclk);

    run_seq(tbl1, 3'd0, 4'd0, 1'b0);

    tbl2 = tbl1;
    tbl2[59:50] = {2'b01, 8'hA4};
    stuck1_mask[50] = 1'b1;
    run_seq(tbl2, 3'd5, 4'd1, 1'b0);

    stuck1_mask = 80'd0;
    stuck1_mask[27] = 1'b1; stuck1_mask[37] = 1'b1; stuck1_mask[77] = 1'b1;
    run_seq(tbl1, 3'd2, 4'd3, 1'b0);

    // Reset on the 4th write cycle; the model keeps its contents.
    stuck1_mask = 80'd0;
    fuse_table = tbl1;
    start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge rclk);
      start = 1'b0;
      if (i <= 4) chk("rst_wr_rid", {28'd0, wren_a, rid_a}, {28'd0, 1'b1, 3'(i-1)});
      if (i == 4) rst_l = 1'b0;
      if (i == 5) chk("rst_mid_outs", {8'd0, wren_a, rid_a, val_a, en_a, busy_a, done_a, err_a, erid_a, ecnt_a}, 32'd0);
    end
    rst_l = 1'b1;
    @(negedge rclk);
    run_seq(tbl1, 3'd0, 4'd0, 1'b0);

    for (int k = 0; k < 8; k++) tbl6[k*10 +: 10] = 10'($urandom);
    tbl6[9:8] = 2'b00;
    run_seq(tbl6, 3'd0, 4'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
